wide_add_seq: RTL and testbench
===============================

Name: wide_add_seq

Overview:
- Multi-word add/subtract sequencer that time-shares one adder32 instance across NUM_WORDS 32-bit slices.
- Chains carry between slices in a register to form a (NUM_WORDS*32)-bit result.
- Sits between a requester (valid/ready command) and a consumer (valid/ready result).
- Provides wide arithmetic without replicating the adder.

Parameters:
- DATA_WIDTH, 31, MSB index of one slice; slice width is DATA_WIDTH+1, passed unchanged to adder32.
- NUM_WORDS, 4, number of slices per operation; minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  command valid.
- start_ready  output  1  block can accept a command.
- op_sub  input  1  0 = a+b+cin_in; 1 = a-b (a + ~b + 1, cin_in ignored).
- a_in  input  NUM_WORDS*(DATA_WIDTH+1)  operand A, word 0 in LSBs.
- b_in  input  NUM_WORDS*(DATA_WIDTH+1)  operand B, word 0 in LSBs.
- cin_in  input  1  carry-in for add.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- sum_out  output  NUM_WORDS*(DATA_WIDTH+1)  result.
- cout_out  output  1  final carry out of the top slice; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow of the full-width operation.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values: state IDLE; start_ready=1; res_valid=0; busy=0; sum_out=0; cout_out=0; overflow=0; word counter=0; carry register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready, capture a_in, b_in (inverted if op_sub), op_sub, and the initial carry (op_sub ? 1 : cin_in).
  - Clear the counter and the result register, then go to RUN.
- RUN:
  - Runs exactly NUM_WORDS cycles. Cycle k drives adder32 with captured word k of A, word k of B, and the carry register.
  - On each edge, write adder s to sum word k and adder cout to the carry register, then increment k.
  - On the edge where k=NUM_WORDS-1: latch cout_out from the adder cout, and set overflow = (A_msb == B'_msb) && (s_msb != A_msb), where B' is the possibly inverted B. Then go to DONE.
- DONE:
  - res_valid=1; sum_out, cout_out and overflow are held stable.
  - On res_valid&res_ready, go to IDLE. res_valid drops the next cycle and start_ready rises the next cycle.
  - No command is accepted in the same cycle the result is taken.
- Latency: accept edge at cycle 0 -> res_valid high at cycle NUM_WORDS+1 (4 RUN cycles + DONE entry for NUM_WORDS=4). Throughput is one operation per NUM_WORDS+2 cycles minimum.
- start_ready=0 throughout RUN and DONE. start_valid is ignored there; the requester must hold its command.
- sum_out is the registered result; partial words are visible during RUN but only valid when res_valid=1.
- Widths: word counter is $clog2(NUM_WORDS) bits and never exceeds NUM_WORDS-1. All slice arithmetic is modulo 2^(DATA_WIDTH+1), with carry passed only through the carry register.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values and the operation is discarded. After deassertion, the first accepted command behaves as from cold reset.
- res_ready high while not in DONE has no effect.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - localparams WORD_W=DATA_WIDTH+1, CNT_W=$clog2(NUM_WORDS).
- One sub-module: the existing adder32 (DATA_WIDTH passed through), instantiated once as the shared datapath. FSM, counter, operand/result registers and carry register stay in wide_add_seq.

Test Plan (NUM_WORDS=4, 128-bit):
- Add, A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1, cin_in=0 -> sum=0x...0000_0001_0000_0000, cout_out=0, overflow=0, res_valid exactly 5 cycles after the accept edge.
- Add, A=all ones, B=0, cin_in=1 -> sum=0, cout_out=1, overflow=0; carry ripples through all 4 slices.
- Subtract, A=5, B=7 -> sum=0xFFFF...FFFE, cout_out=0 (borrow), overflow=0; subtract with A=7, B=5 -> sum=2, cout_out=1.
- Add, A=0x7FFF...FFFF, B=1 -> sum=0x8000...0000, overflow=1, cout_out=0.
- Backpressure: hold res_ready=0 for 3 cycles in DONE -> res_valid, sum_out and cout_out stable; start_valid pulsed meanwhile is not accepted (start_ready=0).
- Reset mid-op: assert rst in RUN cycle 2 -> outputs at reset values asynchronously. A following add of 3+4 returns sum=7 with no residue in the upper words.

Source files
------------

// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package wide_add_seq_pkg;

  // Default geometry: 4 slices of 32 bits form a 128-bit operation.
  localparam int DEF_DATA_WIDTH = 31;
  localparam int DEF_NUM_WORDS  = 4;

  // Slice width and word-counter width for the default geometry.
  localparam int WORD_W = DEF_DATA_WIDTH + 1;
  localparam int CNT_W  = $clog2(DEF_NUM_WORDS);

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement overflow of a full-width add: both addends share a
  // sign and the result's sign differs from it. For subtract the caller
  // passes the already-inverted B sign.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder32.sv
// One-slice ripple adder with carry in/out, shared by the wide sequencer.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational datapath.
module adder32 #(
  parameter int DATA_WIDTH = 31
) (
  input  logic [DATA_WIDTH:0] a,
  input  logic [DATA_WIDTH:0] b,
  input  logic                cin,
  output logic [DATA_WIDTH:0] s,
  output logic                cout
);

  // Extend by one bit so the carry out of the top bit is captured.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{(DATA_WIDTH + 1){1'b0}}, cin};

endmodule

// File: rtl/wide_add_seq.sv
// Wide add/subtract: one shared slice adder walks NUM_WORDS words, carry kept in a register.
// Latency: result valid NUM_WORDS edges after the accept edge (cycle NUM_WORDS+1 counting the accept cycle as 0).
// Backpressure: start_ready low while busy; result held stable in DONE until res_ready.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_valid,
  output logic                                 start_ready,
  input  logic                                 op_sub,
  input  logic [NUM_WORDS*(DATA_WIDTH+1)-1:0]  a_in,
  input  logic [NUM_WORDS*(DATA_WIDTH+1)-1:0]  b_in,
  input  logic                                 cin_in,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [NUM_WORDS*(DATA_WIDTH+1)-1:0]  sum_out,
  output logic                                 cout_out,
  output logic                                 overflow,
  output logic                                 busy
);

  // Slice width and counter width for this instance's geometry.
  // NUM_WORDS is at least 2, so the counter is at least one bit wide.
  localparam int SW = DATA_WIDTH + 1;
  localparam int CW = $clog2(NUM_WORDS);
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           carry;

  // Captured operands (B already inverted for subtract) and result words.
  logic [SW-1:0]  a_w   [NUM_WORDS];
  logic [SW-1:0]  b_w   [NUM_WORDS];
  logic [SW-1:0]  r_w   [NUM_WORDS];

  // Input buses split into words, word 0 in the LSBs.
  logic [SW-1:0]  a_in_w [NUM_WORDS];
  logic [SW-1:0]  b_in_w [NUM_WORDS];

  // Shared adder connections.
  logic [SW-1:0]  add_a;
  logic [SW-1:0]  add_b;
  logic [SW-1:0]  add_s;
  logic           add_co;

  // Word-level views of the wide buses.
  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_words
    assign a_in_w[i]             = a_in[i*SW +: SW];
    assign b_in_w[i]             = b_in[i*SW +: SW];
    assign sum_out[i*SW +: SW]   = r_w[i];
  end

  // The word counter selects which captured slice feeds the adder.
  assign add_a = a_w[cnt];
  assign add_b = b_w[cnt];

  adder32 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .s    (add_s),
    .cout (add_co)
  );

  // Sequencer: capture in IDLE, one slice per cycle in RUN, hold in DONE.
  // Subtract is folded in at capture time (B inverted, carry preset to 1),
  // so RUN is identical for both operations and op_sub need not be kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      cout_out    <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      carry       <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        a_w[i] <= '0;
        b_w[i] <= '0;
        r_w[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              a_w[i] <= a_in_w[i];
              b_w[i] <= op_sub ? ~b_in_w[i] : b_in_w[i];
              r_w[i] <= '0;
            end
            carry       <= op_sub | cin_in;
            cnt         <= '0;
            cout_out    <= 1'b0;
            overflow    <= 1'b0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_w[cnt] <= add_s;
          carry    <= add_co;
          if (cnt == LAST) begin
            // Top slice: its carry and sign bits describe the whole result.
            cout_out  <= add_co;
            overflow  <= signed_ovf(add_a[SW-1], add_b[SW-1], add_s[SW-1]);
            cnt       <= '0;
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          // Going back through IDLE keeps a new command out of the take cycle.
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          res_valid   <= 1'b0;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          cnt         <= '0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq against a full-width arithmetic model.
// Latency: checks result appears in cycle NUM_WORDS+1 after the accept cycle.
// Backpressure: exercises held results, ignored commands and the take cycle.
module tb_wide_add_seq;
  import wide_add_seq_pkg::*;

  localparam int NW = DEF_NUM_WORDS;
  localparam int W  = NW * WORD_W;

  logic          clk;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic          op_sub;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          cin_in;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  sum_out;
  logic          cout_out;
  logic          overflow;
  logic          busy;

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 0;

  // Model state: is an operation outstanding, edges since its accept,
  // and the expected full-width result.
  bit           inflight = 0;
  int           age      = 0;
  logic [W-1:0] m_sum    = '0;
  logic         m_cout   = 1'b0;
  logic         m_ovf    = 1'b0;

  wide_add_seq #(
    .DATA_WIDTH (DEF_DATA_WIDTH),
    .NUM_WORDS  (NW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_sub      (op_sub),
    .a_in        (a_in),
    .b_in        (b_in),
    .cin_in      (cin_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum_out     (sum_out),
    .cout_out    (cout_out),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full-width arithmetic straight from the operation definition.
  task automatic model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output logic [W-1:0] s, output logic co,
                       output logic ov);
    logic [W-1:0] bb;
    logic [W:0]   t;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
    s  = t[W-1:0];
    co = t[W];
    ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      2:       v = {1'b0, {(W-1){1'b1}}};
      3:       v = {1'b1, {(W-1){1'b0}}};
      default: v = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v;
  endfunction

  // Protocol model, advanced on the same edges the DUT sees.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight = 0;
      age      = 0;
    end else if (!inflight) begin
      if (start_valid) begin
        inflight = 1;
        age      = 0;
        model(op_sub, a_in, b_in, cin_in, m_sum, m_cout, m_ovf);
      end
    end else if (age >= NW) begin
      if (res_ready) inflight = 0;
    end else begin
      age++;
    end
  end

  // Every cycle: handshake outputs follow the model; results match when valid.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        chk("rst_res_valid", W'(res_valid), W'(0));
        chk("rst_start_ready", W'(start_ready), W'(1));
        chk("rst_sum", sum_out, '0);
      end else begin
        chk("mon_busy", W'(busy), W'(inflight));
        chk("mon_start_ready", W'(start_ready), W'(!inflight));
        chk("mon_res_valid", W'(res_valid), W'(inflight && age >= NW));
        if (inflight && age >= NW) begin
          chk("mon_sum", sum_out, m_sum);
          chk("mon_cout", W'(cout_out), W'(m_cout));
          chk("mon_ovf", W'(overflow), W'(m_ovf));
        end
      end
    end
  end

  // One complete operation: present, accept, wait, hold for `hold` cycles, take.
  task automatic do_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input int hold, input bit lit,
                       input logic [W-1:0] es, input logic eco, input logic eov);
    logic [W-1:0] ms;
    logic         mco, mov;
    int           n;
    if (lit) begin
      model(sub, a, b, cin, ms, mco, mov);
      chk("model_sum", ms, es);
      chk("model_cout", W'(mco), W'(eco));
      chk("model_ovf", W'(mov), W'(eov));
    end
    @(posedge clk); #1;
    op_sub = sub; a_in = a; b_in = b; cin_in = cin;
    start_valid = 1'b1; res_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!start_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", W'(start_ready), W'(1));
    @(posedge clk); #1;
    // Scramble inputs after accept: the captured command must be used.
    start_valid = 1'b0;
    a_in = rnd_word(); b_in = rnd_word(); cin_in = 1'($urandom); op_sub = 1'($urandom);
    n = 1;
    @(negedge clk);
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency_cycles", W'(n), W'(NW + 1));
    if (lit) begin
      chk("lit_sum", sum_out, es);
      chk("lit_cout", W'(cout_out), W'(eco));
      chk("lit_ovf", W'(overflow), W'(eov));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      start_valid = (h == 1);
      a_in = rnd_word();
      @(negedge clk);
      chk("hold_res_valid", W'(res_valid), W'(1));
      chk("hold_start_ready", W'(start_ready), W'(0));
    end
    // Take the result with a command already waiting: it must not slip in.
    @(posedge clk); #1;
    start_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    chk("after_take_res_valid", W'(res_valid), W'(0));
    chk("after_take_busy", W'(busy), W'(0));
    chk("after_take_start_ready", W'(start_ready), W'(1));
  endtask

  initial begin
    rst = 1'b0; start_valid = 1'b0; op_sub = 1'b0; a_in = '0; b_in = '0;
    cin_in = 1'b0; res_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_start_ready", W'(start_ready), W'(1));
    chk("reset_res_valid", W'(res_valid), W'(0));
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_sum", sum_out, '0);
    chk("reset_cout_ovf", W'({cout_out, overflow}), W'(0));
    mon_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Carry out of word 0 into word 1.
    do_op(1'b0, W'(32'hFFFF_FFFF), W'(1), 1'b0, 0, 1, W'(64'h1_0000_0000), 1'b0, 1'b0);
    // Carry ripples through every slice; held 3 cycles under backpressure.
    do_op(1'b0, '1, '0, 1'b1, 3, 1, '0, 1'b1, 1'b0);
    // Subtract with and without borrow.
    do_op(1'b1, W'(5), W'(7), 1'b0, 0, 1, {{(W-2){1'b1}}, 2'b10}, 1'b0, 1'b0);
    do_op(1'b1, W'(7), W'(5), 1'b1, 1, 1, W'(2), 1'b1, 1'b0);
    // Signed overflow at the top boundary.
    do_op(1'b0, {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 0, 1,
          {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);

    // Reset in the middle of RUN discards the operation at once.
    @(posedge clk); #1;
    op_sub = 1'b0; a_in = '1; b_in = '1; cin_in = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_sum", sum_out, '0);
    chk("midrst_flags", W'({res_valid, busy, cout_out, overflow}), W'(0));
    chk("midrst_start_ready", W'(start_ready), W'(1));
    res_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    do_op(1'b0, W'(3), W'(4), 1'b0, 0, 1, W'(7), 1'b0, 1'b0);

    // Randomized traffic checked by the model and monitor.
    for (int i = 0; i < 25; i++) begin
      do_op(1'($urandom), rnd_word(), rnd_word(), 1'($urandom),
            $urandom_range(0, 3), 0, '0, 1'b0, 1'b0);
    end

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
